mem_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared memory bus used by up to four requesters (CPU, DMA, video fetch, debug port).
- Drives the select of the external mux4 instances (address, write data, write strobe) and demux2/demux-style return paths.
- Grants one requester at a time and holds the grant for a fixed-latency access, stretchable by a wait input.
- Issues a single-cycle acknowledge per completed access.

---
 rtl/bus_defs.sv | 27 ++
 rtl/rr_pick4.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_defs.sv
`default_nettype none
// ============================================================================
//  Module      : bus_defs (package)
//  Description : Shared definitions for the shared memory bus arbiter:
//                requester count, FSM state encodings and a one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_defs;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Decode a requester index into its one-hot grant/ack vector.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational 4-way round-robin priority encoder. Searches
//                last+1, last+2, last+3, last (mod 4) and returns the first
//                requester found.
//  Ports       : req[3:0]   - request vector
//                last[1:0]  - most recently granted requester
//                winner[1:0]- selected requester (== last when none pending)
//                any        - at least one request pending
//  Revision    : 1.0 - initial release
// ============================================================================
import bus_defs::*;

module rr_pick4 (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      winner,
  output logic            any
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    winner  = last;
    w_found = 1'b0;
    w_idx   = last;
    // k = 4 wraps to last itself, so the previous winner is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = last + k[1:0];
      if (!w_found && req[w_idx]) begin
        winner  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Round-robin arbiter/sequencer for one shared memory bus with
//                four requesters. Grants one requester, holds the grant for
//                WAIT_CYCLES+1 bus cycles (stretched by mem_wait), then pulses
//                a one-cycle ack. All outputs are registered.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                req[3:0] - requests, held until ack
//                mem_wait - memory stall, freezes the access counter
//                sel[1:0] - granted requester index (external mux select)
//                gnt[3:0] - one-hot grant while busy
//                mem_en   - bus cycle active
//                ack[3:0] - one-cycle completion pulse
//                busy     - high in ACCESS and DONE
//  Revision    : 1.0 - initial release
// ============================================================================
import bus_defs::*;

module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            mem_wait,
  output logic [1:0]      sel,
  output logic [NREQ-1:0] gnt,
  output logic            mem_en,
  output logic [NREQ-1:0] ack,
  output logic            busy
);

  state_t                r_state,  w_state_nxt;
  logic [1:0]            r_sel,    w_sel_nxt;
  logic [NREQ-1:0]       r_gnt,    w_gnt_nxt;
  logic                  r_mem_en, w_mem_en_nxt;
  logic [NREQ-1:0]       r_ack,    w_ack_nxt;
  logic                  r_busy,   w_busy_nxt;
  logic [1:0]            r_last,   w_last_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt,    w_cnt_nxt;

  logic [1:0]            w_winner;
  logic                  w_any;

  rr_pick4 u_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_winner),
    .any    (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= 2'b00;
      r_gnt    <= '0;
      r_mem_en <= 1'b0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_last   <= 2'd3;   // requester 0 gets first priority after reset
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_gnt    <= w_gnt_nxt;
      r_mem_en <= w_mem_en_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= w_busy_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_gnt_nxt    = r_gnt;
    w_mem_en_nxt = r_mem_en;
    w_ack_nxt    = '0;
    w_busy_nxt   = r_busy;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      ST_IDLE: begin
        // sel is only updated here, so it stays put for the whole busy window.
        if (w_any) begin
          w_state_nxt  = ST_ACCESS;
          w_sel_nxt    = w_winner;
          w_gnt_nxt    = onehot4(w_winner);
          w_mem_en_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_last_nxt   = w_winner;
          w_cnt_nxt    = CNT_WIDTH'(WAIT_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (mem_wait) begin
          w_state_nxt = ST_ACCESS;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt  = ST_DONE;
          w_mem_en_nxt = 1'b0;
          w_ack_nxt    = onehot4(r_sel);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_gnt_nxt    = '0;
        w_mem_en_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  assign sel    = r_sel;
  assign gnt    = r_gnt;
  assign mem_en = r_mem_en;
  assign ack    = r_ack;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter. Directed stimulus
//                pushes expected acks (value, sel, cycle) into a queue; a
//                monitor pops and compares whenever ack is non-zero.
//                A second instance built with WAIT_CYCLES=0 is checked
//                directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] sel;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mem_wait;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       mem_en;
  logic [3:0] ack;
  logic       busy;

  logic [3:0] req0;
  logic       mem_wait0;
  logic [1:0] sel0;
  logic [3:0] gnt0;
  logic       mem_en0;
  logic [3:0] ack0;
  logic       busy0;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  logic       prev_busy = 1'b0;
  logic [1:0] prev_sel  = 2'b00;
  logic       sel_moved = 1'b0;

  mem_bus_arbiter #(.WAIT_CYCLES(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .mem_wait(mem_wait),
    .sel(sel), .gnt(gnt), .mem_en(mem_en), .ack(ack), .busy(busy)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(0), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .mem_wait(mem_wait0),
    .sel(sel0), .gnt(gnt0), .mem_en(mem_en0), .ack(ack0), .busy(busy0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sel stability tracking plus scoreboard compare on every ack.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_busy <= 1'b0;
    end else begin
      if (busy && prev_busy && (sel != prev_sel)) sel_moved <= 1'b1;
      prev_busy <= busy;
      prev_sel  <= sel;
      if (ack != 4'b0000) begin
        if (q.size() == 0) begin
          check("unexpected_ack", {28'd0, ack}, 32'd0);
        end else begin
          e = q.pop_front();
          check("ack_value", {28'd0, ack}, {28'd0, e.ack});
          check("ack_cycle", cyc, e.cyc);
          check("ack_sel",   {30'd0, sel}, {30'd0, e.sel});
          check("ack_gnt",   {28'd0, gnt}, {28'd0, e.ack});
          check("sel_stable_while_busy", {31'd0, sel_moved}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    rst = 1'b1; req = 4'b0000; mem_wait = 1'b0;
    req0 = 4'b0000; mem_wait0 = 1'b0;
    repeat (3) step();

    // ---- reset state ----
    @(negedge clk);
    check("rst_sel",    {30'd0, sel},  32'd0);
    check("rst_gnt",    {28'd0, gnt},  32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_ack",    {28'd0, ack},  32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;

    // ---- single access, no waits: ack at cycle 4 ----
    c0 = cyc;
    req = 4'b0001;
    q.push_back('{ack: 4'b0001, sel: 2'd0, cyc: c0 + 4});
    step();
    @(negedge clk);
    check("t1_sel_c1",    {30'd0, sel},    32'd0);
    check("t1_gnt_c1",    {28'd0, gnt},    32'h1);
    check("t1_mem_en_c1", {31'd0, mem_en}, 32'd1);
    check("t1_busy_c1",   {31'd0, busy},   32'd1);
    step(); step();
    @(negedge clk);
    check("t1_mem_en_c3", {31'd0, mem_en}, 32'd1);
    step();
    req = 4'b0000;
    @(negedge clk);
    check("t1_mem_en_c4", {31'd0, mem_en}, 32'd0);
    step();
    @(negedge clk);
    check("t1_busy_c5", {31'd0, busy}, 32'd0);
    check("t1_gnt_c5",  {28'd0, gnt},  32'd0);
    step();

    // ---- round robin from fresh reset: order 0,1,2,3,0 ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    c0 = cyc;
    req = 4'b1111;
    q.push_back('{ack: 4'b0001, sel: 2'd0, cyc: c0 + 4});
    q.push_back('{ack: 4'b0010, sel: 2'd1, cyc: c0 + 9});
    q.push_back('{ack: 4'b0100, sel: 2'd2, cyc: c0 + 14});
    q.push_back('{ack: 4'b1000, sel: 2'd3, cyc: c0 + 19});
    q.push_back('{ack: 4'b0001, sel: 2'd0, cyc: c0 + 24});
    for (int k = 0; k <= 26; k++) begin
      if (k >= 4 && (k - 4) % 5 == 0) req[((k - 4) / 5) % 4] = 1'b0;
      if (k >= 5 && k <= 20 && (k - 5) % 5 == 0) req[((k - 5) / 5) % 4] = 1'b1;
      if (k == 24) req = 4'b0000;
      step();
    end
    check("rr_all_acks_seen", q.size(), 32'd0);

    // ---- mem_wait for 3 cycles: 6 mem_en cycles, ack 3 cycles late ----
    c0 = cyc;
    n = 0;
    req = 4'b0001;
    q.push_back('{ack: 4'b0001, sel: 2'd0, cyc: c0 + 7});
    for (int k = 0; k <= 9; k++) begin
      mem_wait = (k >= 2 && k <= 4);
      if (k == 7) req = 4'b0000;
      @(negedge clk);
      if (mem_en) n++;
      step();
    end
    check("wait_mem_en_cycles", n, 32'd6);

    // ---- req[2] dropped after one ACCESS cycle: access still completes ----
    c0 = cyc;
    req = 4'b0100;
    q.push_back('{ack: 4'b0100, sel: 2'd2, cyc: c0 + 4});
    for (int k = 0; k <= 9; k++) begin
      if (k == 2) req = 4'b0000;
      step();
    end
    @(negedge clk);
    check("drop_idle_busy",   {31'd0, busy},   32'd0);
    check("drop_idle_mem_en", {31'd0, mem_en}, 32'd0);
    check("drop_all_acks_seen", q.size(), 32'd0);
    step();

    // ---- rst during ACCESS: access dropped, then req[3] granted ----
    c0 = cyc;
    req = 4'b0001;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1000;
    @(negedge clk);
    check("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mid_gnt",    {28'd0, gnt},    32'd0);
    check("rst_mid_sel",    {30'd0, sel},    32'd0);
    check("rst_mid_busy",   {31'd0, busy},   32'd0);
    c0 = cyc;
    q.push_back('{ack: 4'b1000, sel: 2'd3, cyc: c0 + 4});
    step();
    @(negedge clk);
    check("rst_then_sel3", {30'd0, sel}, 32'd3);
    check("rst_then_gnt",  {28'd0, gnt}, 32'h8);
    step(); step(); step();
    req = 4'b0000;
    step(); step();

    // ---- WAIT_CYCLES=0 instance ----
    req0 = 4'b0010;
    step();
    @(negedge clk);
    check("w0_mem_en_c1", {31'd0, mem_en0}, 32'd1);
    check("w0_gnt_c1",    {28'd0, gnt0},    32'h2);
    check("w0_sel_c1",    {30'd0, sel0},    32'd1);
    step();
    req0 = 4'b0000;
    @(negedge clk);
    check("w0_mem_en_c2", {31'd0, mem_en0}, 32'd0);
    check("w0_ack_c2",    {28'd0, ack0},    32'h2);
    step();
    @(negedge clk);
    check("w0_ack_c3",  {28'd0, ack0},  32'd0);
    check("w0_busy_c3", {31'd0, busy0}, 32'd0);
    step(); step();

    check("final_queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
